// File: rtl/hssi_tc_mb_pkg.sv
// Shared constants for the HSSI traffic-controller mailbox bridge: CSR offsets,
// command encodings, status bit positions, FSM states and the abort pattern.
package hssi_tc_mb_pkg;

  localparam logic [3:0] OFFS_CMD    = 4'h0;
  localparam logic [3:0] OFFS_ADDR   = 4'h4;
  localparam logic [3:0] OFFS_RDDATA = 4'h8;
  localparam logic [3:0] OFFS_WRDATA = 4'hC;

  localparam logic [1:0] CMD_NOOP = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;

  localparam int ST_RD_PEND = 0;
  localparam int ST_WR_PEND = 1;
  localparam int ST_ACK     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_TIMEOUT = 4;

  localparam logic [31:0] RDDATA_TMO = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/hssi_tc_mb_timer.sv
// Loadable transaction timeout counter; o_expire is high while the count sits
// at TIMEOUT_CYC-1, and the count holds there until reloaded.
module hssi_tc_mb_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/hssi_tc_mailbox_bridge.sv
// Host mailbox (CMD/ADDRESS/RDDATA/WRDATA) that runs one Avalon-MM transaction
// per accepted command against the HSSI traffic-controller register space.
module hssi_tc_mailbox_bridge
  import hssi_tc_mb_pkg::*;
#(
  parameter int TC_AW       = 16,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_wr,
  input  logic             csr_rd,
  input  logic [3:0]       csr_offs,
  input  logic [DW-1:0]    csr_wdata,
  output logic [DW-1:0]    csr_rdata,
  output logic             csr_rvalid,
  output logic [TC_AW-1:0] tc_addr,
  output logic             tc_write,
  output logic             tc_read,
  output logic [DW-1:0]    tc_writedata,
  input  logic             tc_waitrequest,
  input  logic [DW-1:0]    tc_readdata,
  input  logic             tc_readdatavalid
);

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_address;
  logic [DW-1:0] r_wrdata;
  logic [DW-1:0] r_rddata;
  logic          r_rd_pend;
  logic          r_wr_pend;
  logic          r_ack;
  logic          r_timeout;
  logic [DW-1:0] r_csr_rdata;
  logic          r_csr_rvalid;

  logic          w_idle;
  logic          w_cmd_wr;
  logic          w_acc_rd;
  logic          w_acc_wr;
  logic          w_addr_wr;
  logic          w_wrdata_wr;
  logic          w_tc_read;
  logic          w_tc_write;
  logic          w_capture;
  logic          w_tmo_evt;
  logic          w_tmr_load;
  logic          w_tmr_en;
  logic          w_expire;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rd_mux;

  assign w_idle      = (r_state == S_IDLE);
  assign w_cmd_wr    = csr_wr && (csr_offs == OFFS_CMD);
  assign w_acc_rd    = w_cmd_wr && w_idle && (csr_wdata[1:0] == CMD_RD);
  assign w_acc_wr    = w_cmd_wr && w_idle && (csr_wdata[1:0] == CMD_WR);
  assign w_addr_wr   = csr_wr && (csr_offs == OFFS_ADDR) && w_idle;
  assign w_wrdata_wr = csr_wr && (csr_offs == OFFS_WRDATA) && w_idle;

  hssi_tc_mb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion is checked before expiry so a transfer finishing on the last
  // counted cycle is reported as a normal ack, not a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_tc_read   = 1'b0;
    w_tc_write  = 1'b0;
    w_capture   = 1'b0;
    w_tmo_evt   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_rd) begin
          w_state_nxt = S_RD_REQ;
          w_tmr_load  = 1'b1;
        end else if (w_acc_wr) begin
          w_state_nxt = S_WR_REQ;
          w_tmr_load  = 1'b1;
        end
      end
      S_WR_REQ: begin
        w_tc_write = 1'b1;
        w_tmr_en   = 1'b1;
        if (!tc_waitrequest) begin
          w_state_nxt = S_DONE;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_tmo_evt   = 1'b1;
        end
      end
      S_RD_REQ: begin
        w_tc_read = 1'b1;
        w_tmr_en  = 1'b1;
        if (!tc_waitrequest && tc_readdatavalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_tmo_evt   = 1'b1;
        end else if (!tc_waitrequest) begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_tmr_en = 1'b1;
        if (tc_readdatavalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_tmo_evt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_address <= '0;
      r_wrdata  <= '0;
      r_rddata  <= '0;
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_addr_wr) begin
        r_address <= csr_wdata;
      end
      if (w_wrdata_wr) begin
        r_wrdata <= csr_wdata;
      end
      if (w_capture) begin
        r_rddata <= tc_readdata;
      end else if (w_tmo_evt) begin
        r_rddata <= DW'(RDDATA_TMO);
      end
      if (w_acc_rd || w_acc_wr) begin
        r_rd_pend <= w_acc_rd;
        r_wr_pend <= w_acc_wr;
        r_ack     <= 1'b0;
        r_timeout <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_rd_pend <= 1'b0;
        r_wr_pend <= 1'b0;
        r_ack     <= 1'b1;
      end else if (w_tmo_evt) begin
        r_rd_pend <= 1'b0;
        r_wr_pend <= 1'b0;
        r_ack     <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[ST_RD_PEND] = r_rd_pend;
    w_status[ST_WR_PEND] = r_wr_pend;
    w_status[ST_ACK]     = r_ack;
    w_status[ST_BUSY]    = !w_idle;
    w_status[ST_TIMEOUT] = r_timeout;
  end

  always_comb begin
    w_rd_mux = '0;
    case (csr_offs)
      OFFS_CMD:    w_rd_mux = w_status;
      OFFS_ADDR:   w_rd_mux = r_address;
      OFFS_RDDATA: w_rd_mux = r_rddata;
      OFFS_WRDATA: w_rd_mux = r_wrdata;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csr_rdata  <= '0;
      r_csr_rvalid <= 1'b0;
    end else begin
      r_csr_rvalid <= csr_rd;
      r_csr_rdata  <= csr_rd ? w_rd_mux : '0;
    end
  end

  // Address/data are only presented while a request is on the bus.
  assign tc_read      = w_tc_read;
  assign tc_write     = w_tc_write;
  assign tc_addr      = (w_tc_read || w_tc_write) ? r_address[TC_AW-1:0] : '0;
  assign tc_writedata = w_tc_write ? r_wrdata : '0;
  assign csr_rdata    = r_csr_rdata;
  assign csr_rvalid   = r_csr_rvalid;

endmodule

// File: tb/tb_hssi_tc_mailbox_bridge.sv
// Directed bench for the mailbox bridge: scoreboarded CSR reads and Avalon
// transfers, covering write, read, backpressure, busy collision, timeout, reset.
module tb_hssi_tc_mailbox_bridge;

  localparam int TC_AW = 16;
  localparam int DW    = 32;
  localparam int TMO   = 16;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic          clk;
  logic          rst;
  logic          csr_wr;
  logic          csr_rd;
  logic [3:0]    csr_offs;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid;
  logic [15:0]   tc_addr;
  logic          tc_write;
  logic          tc_read;
  logic [31:0]   tc_writedata;
  logic          tc_waitrequest;
  logic [31:0]   tc_readdata;
  logic          tc_readdatavalid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_rd_q[$];
  xfer_t       exp_tc_q[$];
  xfer_t       obs_q[$];

  hssi_tc_mailbox_bridge #(
    .TC_AW       (TC_AW),
    .DW          (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .csr_wr           (csr_wr),
    .csr_rd           (csr_rd),
    .csr_offs         (csr_offs),
    .csr_wdata        (csr_wdata),
    .csr_rdata        (csr_rdata),
    .csr_rvalid       (csr_rvalid),
    .tc_addr          (tc_addr),
    .tc_write         (tc_write),
    .tc_read          (tc_read),
    .tc_writedata     (tc_writedata),
    .tc_waitrequest   (tc_waitrequest),
    .tc_readdata      (tc_readdata),
    .tc_readdatavalid (tc_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every Avalon transfer the bridge completes (request with no wait).
  always @(negedge clk) begin
    if (!rst && (tc_write || tc_read) && !tc_waitrequest) begin
      obs_q.push_back('{wr: tc_write, addr: tc_addr, data: tc_writedata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [3:0] offs, input logic [31:0] data);
    csr_wr    = 1'b1;
    csr_offs  = offs;
    csr_wdata = data;
    tick();
    csr_wr    = 1'b0;
    csr_offs  = 4'h0;
    csr_wdata = 32'h0;
  endtask

  task automatic csr_read(input logic [3:0] offs, input logic [31:0] exp, input string tag);
    int n;
    logic [31:0] e;
    exp_rd_q.push_back(exp);
    csr_rd   = 1'b1;
    csr_offs = offs;
    tick();
    csr_rd   = 1'b0;
    csr_offs = 4'h0;
    n = 0;
    while (csr_rvalid !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    e = exp_rd_q.pop_front();
    if (csr_rvalid !== 1'b1) chk({tag, "_rvalid"}, 32'(csr_rvalid), 32'h1);
    else chk(tag, csr_rdata, e);
  endtask

  task automatic check_xfer(input string tag);
    xfer_t o;
    xfer_t e;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_tc_q.size()));
    while (obs_q.size() > 0 && exp_tc_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_tc_q.pop_front();
      chk({tag, "_wr"}, 32'(o.wr), 32'(e.wr));
      chk({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
      if (e.wr) chk({tag, "_data"}, o.data, e.data);
    end
    obs_q.delete();
    exp_tc_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    csr_wr = 1'b0; csr_rd = 1'b0; csr_offs = 4'h0; csr_wdata = 32'h0;
    tc_waitrequest = 1'b0; tc_readdata = 32'h0; tc_readdatavalid = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_tc_write", 32'(tc_write), 32'h0);
    chk("rst_tc_read", 32'(tc_read), 32'h0);
    chk("rst_tc_addr", 32'(tc_addr), 32'h0);
    chk("rst_rvalid", 32'(csr_rvalid), 32'h0);
    rst = 1'b0;
    tick();
    csr_read(4'h0, 32'h0, "rst_cmd");
    csr_read(4'h8, 32'h0, "rst_rddata");

    // Plain write, no waitrequest
    csr_write(4'h4, 32'h0000);
    csr_write(4'hC, 32'h20);
    exp_tc_q.push_back('{wr: 1'b1, addr: 16'h0000, data: 32'h20});
    csr_write(4'h0, 32'h2);
    chk("wr_tc_write", 32'(tc_write), 32'h1);
    chk("wr_tc_wdata", tc_writedata, 32'h20);
    tick();
    chk("wr_tc_write_drop", 32'(tc_write), 32'h0);
    tick();
    csr_read(4'h0, 32'h4, "wr_ack");
    check_xfer("wr_xfer");

    // Command 3 is a NOOP: status stays at ack only
    csr_write(4'h0, 32'h3);
    chk("noop_no_write", 32'(tc_write), 32'h0);
    csr_read(4'h0, 32'h4, "noop_status");

    // Read with data 4 cycles after acceptance
    csr_write(4'h4, 32'h101);
    exp_tc_q.push_back('{wr: 1'b0, addr: 16'h0101, data: 32'h0});
    csr_write(4'h0, 32'h1);
    chk("rd_tc_read", 32'(tc_read), 32'h1);
    chk("rd_tc_addr", 32'(tc_addr), 32'h101);
    tick();
    chk("rd_tc_read_drop", 32'(tc_read), 32'h0);
    csr_read(4'h0, 32'h9, "rd_busy");
    tick(); tick();
    tc_readdatavalid = 1'b1; tc_readdata = 32'h1F;
    tick();
    tc_readdatavalid = 1'b0; tc_readdata = 32'h0;
    tick();
    csr_read(4'h0, 32'h4, "rd_ack");
    csr_read(4'h8, 32'h1F, "rd_data");
    check_xfer("rd_xfer");

    // RDDATA is read-only; undefined offsets read 0
    csr_write(4'h8, 32'h1234_5678);
    csr_read(4'h8, 32'h1F, "rddata_ro");
    csr_read(4'h2, 32'h0, "undef_offs");

    // Backpressure: 3 wait cycles, request stable for 4 cycles
    csr_write(4'h4, 32'h200);
    csr_write(4'hC, 32'h1);
    exp_tc_q.push_back('{wr: 1'b1, addr: 16'h0200, data: 32'h1});
    tc_waitrequest = 1'b1;
    csr_write(4'h0, 32'h2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) tc_waitrequest = 1'b0;
      chk("bp_tc_write", 32'(tc_write), 32'h1);
      chk("bp_tc_addr", 32'(tc_addr), 32'h200);
      chk("bp_tc_wdata", tc_writedata, 32'h1);
      tick();
    end
    chk("bp_write_drop", 32'(tc_write), 32'h0);
    tick();
    csr_read(4'h0, 32'h4, "bp_ack");
    check_xfer("bp_xfer");

    // Busy collision: CMD and ADDRESS writes during an in-flight read
    csr_write(4'h4, 32'h104);
    exp_tc_q.push_back('{wr: 1'b0, addr: 16'h0104, data: 32'h0});
    csr_write(4'h0, 32'h1);
    tick();
    csr_write(4'h0, 32'h2);
    csr_write(4'h4, 32'h5);
    chk("col_no_write", 32'(tc_write), 32'h0);
    csr_read(4'h4, 32'h104, "col_addr");
    csr_read(4'h0, 32'h9, "col_status");
    tc_readdatavalid = 1'b1; tc_readdata = 32'hA5A5_0001;
    tick();
    tc_readdatavalid = 1'b0; tc_readdata = 32'h0;
    tick();
    csr_read(4'h0, 32'h4, "col_ack");
    csr_read(4'h8, 32'hA5A5_0001, "col_rddata");
    check_xfer("col_xfer");

    // Timeout: read held off by waitrequest forever
    csr_write(4'h4, 32'h102);
    tc_waitrequest = 1'b1;
    csr_write(4'h0, 32'h1);
    n = 0;
    while (tc_read === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_read_cycles", 32'(n), 32'(TMO));
    tc_waitrequest = 1'b0;
    csr_read(4'h0, 32'h14, "tmo_status");
    csr_read(4'h8, 32'hDEAD_BEEF, "tmo_rddata");
    check_xfer("tmo_xfer");

    // Next command clears timeout; completion on the expiry cycle wins
    csr_write(4'h4, 32'h3);
    csr_write(4'hC, 32'h5A);
    exp_tc_q.push_back('{wr: 1'b1, addr: 16'h0003, data: 32'h5A});
    tc_waitrequest = 1'b1;
    csr_write(4'h0, 32'h2);
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 1) tc_waitrequest = 1'b0;
      tick();
    end
    tc_waitrequest = 1'b0;
    tick();
    csr_read(4'h0, 32'h4, "race_status");
    check_xfer("race_xfer");

    // Reset mid-transaction in RD_WAIT with a CSR read response outstanding
    csr_write(4'h4, 32'h103);
    exp_tc_q.push_back('{wr: 1'b0, addr: 16'h0103, data: 32'h0});
    csr_write(4'h0, 32'h1);
    csr_rd = 1'b1; csr_offs = 4'h0;
    tick();
    csr_rd = 1'b0;
    chk("prerst_rvalid", 32'(csr_rvalid), 32'h1);
    chk("prerst_status", csr_rdata, 32'h9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(csr_rvalid), 32'h0);
    chk("mid_rst_rdata", csr_rdata, 32'h0);
    chk("mid_rst_tc_read", 32'(tc_read), 32'h0);
    chk("mid_rst_tc_write", 32'(tc_write), 32'h0);
    chk("mid_rst_tc_addr", 32'(tc_addr), 32'h0);
    chk("mid_rst_tc_wdata", tc_writedata, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tc_readdatavalid = 1'b1; tc_readdata = 32'h77;
    tick();
    tc_readdatavalid = 1'b0; tc_readdata = 32'h0;
    csr_read(4'h0, 32'h0, "post_rst_status");
    csr_read(4'h8, 32'h0, "post_rst_rddata");
    csr_read(4'h4, 32'h0, "post_rst_addr");
    check_xfer("rst_xfer");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
